// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int STREAK_W   = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_I    = 2'd1,
      ARB_D    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the idle slot plus the fetch-starvation streak counter.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STREAK_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic if_req,
   input  logic dm_req,
   output logic grant_i,
   output logic grant_d
);

   localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STREAK_MAX);

   logic [STREAK_W-1:0] streak;
   logic                force_i;

   // Data wins unless fetch has already been passed over SMAX times.
   assign force_i = if_req && (streak == SMAX);
   assign grant_d = arb_en && dm_req && !force_i;
   assign grant_i = arb_en && if_req && !grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (arb_en) begin
         if (!if_req || grant_i) begin
            streak <= '0;
         end else if (streak != SMAX) begin
            streak <= streak + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read) and data (read/write);
// one access in flight, strobes held until the memory's done pulse.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              dm_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done
);

   arb_state_e state;
   logic       arb_en;
   logic       grant_i;
   logic       grant_d;

   assign arb_en = (state == ARB_IDLE);

   mem_arb_prio #(
      .STREAK_MAX (STREAK_MAX)
   ) u_prio (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (arb_en),
      .if_req  (if_req),
      .dm_req  (dm_req),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   // mem_done only counts for the current owner; idle pulses are dropped.
   assign if_done  = (state == ARB_I) && mem_done;
   assign dm_done  = (state == ARB_D) && mem_done;
   assign if_rdata = if_done ? mem_rdata : '0;
   assign dm_rdata = dm_done ? mem_rdata : '0;
   assign if_stall = if_req && !if_done;
   assign dm_stall = dm_req && !dm_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         mem_addr  <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (grant_d) begin
                  state     <= ARB_D;
                  mem_addr  <= dm_addr;
                  mem_re    <= !dm_we;
                  mem_we    <= dm_we;
                  mem_wdata <= dm_wdata;
               end else if (grant_i) begin
                  state    <= ARB_I;
                  mem_addr <= if_addr;
                  mem_re   <= 1'b1;
                  mem_we   <= 1'b0;
               end
            end
            ARB_I, ARB_D: begin
               if (mem_done) begin
                  state  <= ARB_IDLE;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               mem_re <= 1'b0;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model
// and a transaction-level arbitration reference.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;
   localparam int LAT  = 3;

   typedef struct packed {
      logic        we;
      logic [15:0] data;
   } dm_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic [15:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [15:0] dm_addr = '0;
   logic [15:0] dm_wdata = '0;
   logic [15:0] dm_rdata;
   logic        dm_done;
   logic        dm_stall;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .STREAK_MAX (SMAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_done   (dm_done),
      .dm_stall  (dm_stall),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done)
   );

   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a == 16'h0010) return 16'hA123;
      return (a * 16'h9E37) ^ 16'h1234;
   endfunction

   // Memory model: done pulse 3 cycles after the strobe rises.
   logic [15:0] mem [0:1023];
   bit          wr_flag [0:1023];
   logic [15:0] junk = '0;
   logic        stray = 1'b0;
   logic        mem_done_m;
   int          lat_cnt = 0;

   assign mem_done_m = (mem_re || mem_we) && (lat_cnt == LAT);
   assign mem_done   = mem_done_m || stray;
   assign mem_rdata  = !mem_done ? junk :
                       wr_flag[mem_addr[9:0]] ? mem[mem_addr[9:0]] :
                       init_val(mem_addr);

   always @(posedge clk) begin
      junk <= 16'($urandom);
      if ((mem_re || mem_we) && !mem_done_m) lat_cnt <= lat_cnt + 1;
      else lat_cnt <= 0;
      if (mem_done_m && mem_we) begin
         mem[mem_addr[9:0]]     <= mem_wdata;
         wr_flag[mem_addr[9:0]] <= 1'b1;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   logic [15:0] ref_mem [0:1023];
   logic [15:0] if_q [$];
   dm_exp_t     dm_q [$];

   // Reference arbitration: decide each idle slot's winner from the rules.
   bit          model_en = 1'b0;
   int          run = 0;
   bit          pend = 1'b0;
   bit          pend_any = 1'b0;
   bit          pend_wr = 1'b0;
   logic [17:0] pend_exp = '0;
   logic [15:0] pend_wd = '0;
   int          start_cyc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         chk("if_stall", if_stall, if_req & ~if_done);
         chk("dm_stall", dm_stall, dm_req & ~dm_done);
         chk("done_excl", if_done & dm_done, 0);
         if (if_done) begin
            if (if_q.size() == 0) chk("if_unexpected_done", 1, 0);
            else chk("if_rdata", if_rdata, if_q.pop_front());
         end else begin
            chk("if_rdata_mask", if_rdata, 0);
         end
         if (dm_done) begin
            if (dm_q.size() == 0) begin
               chk("dm_unexpected_done", 1, 0);
            end else begin
               dm_exp_t e;
               e = dm_q.pop_front();
               if (!e.we) chk("dm_rdata", dm_rdata, e.data);
            end
         end else begin
            chk("dm_rdata_mask", dm_rdata, 0);
         end
         if (!model_en) begin
            pend = 1'b0;
            run  = 0;
         end else begin
            if (pend) begin
               if (pend_any) begin
                  chk("grant", {mem_re, mem_we, mem_addr}, pend_exp);
                  if (pend_wr) chk("mem_wdata", mem_wdata, pend_wd);
                  start_cyc = cyc;
               end else begin
                  chk("no_grant", {mem_re, mem_we}, 2'b00);
               end
               pend = 1'b0;
            end
            if (if_done || dm_done) chk("latency", 32'(cyc - start_cyc), LAT);
            if (!(mem_re || mem_we)) begin
               pend     = 1'b1;
               pend_any = if_req || dm_req;
               pend_wr  = 1'b0;
               if (dm_req && !(if_req && run == SMAX)) begin
                  pend_exp = {~dm_we, dm_we, dm_addr};
                  pend_wr  = dm_we;
                  pend_wd  = dm_wdata;
                  run = if_req ? ((run < SMAX) ? run + 1 : SMAX) : 0;
               end else if (if_req) begin
                  pend_exp = {2'b10, if_addr};
                  run = 0;
               end else begin
                  run = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_if(input logic [15:0] a, output int dc);
      if_addr = a;
      if_req  = 1'b1;
      if_q.push_back(ref_mem[a[9:0]]);
      dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (if_done) begin
            dc = cyc;
            break;
         end
      end
      if (dc < 0) chk("if_timeout", 1, 0);
      tick();
      if_req = 1'b0;
   endtask

   task automatic do_dm(input logic we, input logic [15:0] a,
                        input logic [15:0] wd, output int dc);
      dm_exp_t e;
      if (we) ref_mem[a[9:0]] = wd;
      e.we   = we;
      e.data = ref_mem[a[9:0]];
      dm_q.push_back(e);
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = wd;
      dm_req   = 1'b1;
      dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dm_done) begin
            dc = cyc;
            break;
         end
      end
      if (dc < 0) chk("dm_timeout", 1, 0);
      tick();
      dm_req = 1'b0;
   endtask

   int c0;
   int d_if;
   int d_dm;
   int dd [6];

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(16'(i));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_done", if_done, 0);
      chk("rst_dm_done", dm_done, 0);
      tick();
      rst = 1'b0;
      model_en = 1'b1;

      // Fetch only
      c0 = cyc;
      fork
         do_if(16'h0010, d_if);
         begin
            @(negedge clk);
            chk("fetch_re_c0", mem_re, 0);
            @(negedge clk);
            chk("fetch_re_c1", mem_re, 1);
            chk("fetch_addr_c1", mem_addr, 16'h0010);
         end
      join
      chk("fetch_done_cyc", 32'(d_if - c0), 4);

      // Simultaneous: data first, fetch after one idle slot
      c0 = cyc;
      fork
         do_if(16'h0020, d_if);
         do_dm(1'b0, 16'h0200, 16'h0000, d_dm);
      join
      chk("simul_dm_done_cyc", 32'(d_dm - c0), 4);
      chk("simul_if_done_cyc", 32'(d_if - c0), 9);

      // Write then read back
      c0 = cyc;
      fork
         do_dm(1'b1, 16'h0300, 16'hBEEF, d_dm);
         begin
            @(negedge clk);
            @(negedge clk);
            chk("write_we_c1", {mem_re, mem_we}, 2'b01);
            chk("write_wdata_c1", mem_wdata, 16'hBEEF);
         end
      join
      chk("write_done_cyc", 32'(d_dm - c0), 4);
      do_dm(1'b0, 16'h0300, 16'h0000, d_dm);

      // Starvation: data re-requests back to back while fetch waits
      c0 = cyc;
      fork
         do_if(16'h0030, d_if);
         for (int k = 0; k < 6; k++) begin
            int t;
            do_dm(1'b0, 16'(16'h0100 + k), 16'h0000, t);
            dd[k] = t;
         end
      join
      chk("starve_first_d", 32'(dd[0] - c0), 4);
      chk("starve_if_after_4d", 32'(d_if - dd[3]), 5);
      chk("starve_d5_after_if", 32'(dd[4] - dd[3]), 10);
      chk("starve_d_resumes", 32'(dd[5] - dd[4]), 5);

      // Reset mid-access, then a stray mem_done while idle
      model_en = 1'b0;
      dm_we   = 1'b0;
      dm_addr = 16'h0200;
      dm_req  = 1'b1;
      tick();
      @(negedge clk);
      chk("rstmid_started", mem_re, 1);
      tick();
      rst    = 1'b1;
      dm_req = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_strobes", {mem_re, mem_we}, 2'b00);
      chk("rstmid_no_done", dm_done, 0);
      tick();
      stray = 1'b1;
      @(negedge clk);
      chk("stray_if_done", if_done, 0);
      chk("stray_dm_done", dm_done, 0);
      chk("stray_dm_rdata", dm_rdata, 0);
      tick();
      stray = 1'b0;
      @(negedge clk);
      chk("stray_no_start", {mem_re, mem_we}, 2'b00);
      tick();
      model_en = 1'b1;

      // Randomized traffic from both stages
      fork
         for (int k = 0; k < 40; k++) begin
            int t;
            do_if(16'($urandom_range(0, 255)), t);
            repeat ($urandom_range(0, 2)) tick();
         end
         for (int k = 0; k < 60; k++) begin
            int t;
            do_dm(1'($urandom_range(0, 1)), 16'($urandom_range(256, 1023)),
                  16'($urandom), t);
            if ($urandom_range(0, 3) == 0) tick();
         end
      join

      repeat (4) tick();
      chk("if_q_drained", if_q.size(), 0);
      chk("dm_q_drained", dm_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
